montgomery_multi_wrapper: RTL and testbench
===========================================

# montgomery_multi_wrapper

Command-driven front end for `NCH` parallel Montgomery multiplier cores (`montgomery`) of operand width `WIDTH`. It sits between the ARM command/status ports and the BRAM/DMA data interface. It loads per-channel operands, starts the masked cores, collects their results, and streams them back. Compared with the fixed two-core wrapper it adds channel masking, result chaining, a completion timeout and a 32-bit status word on port 2.

## Interface
- `WIDTH`, 512, operand/result width per channel
- `NCH`, 2, number of core channels (1..8)
- `TIMEOUT`, 4096, max cycles to wait for masked cores before declaring error (16-bit counter)
- `clk` in 1 — clock, rising edge
- `resetn` in 1 — reset, synchronous, active-low; also drives every core's `resetn`
- `bram_din` in NCH*WIDTH — channel i at `[i*WIDTH +: WIDTH]`
- `bram_din_valid` in 1 — `bram_din` valid this cycle
- `bram_dout` out NCH*WIDTH — result slices; unmasked slices driven 0
- `bram_dout_valid` out 1 — `bram_dout` valid, held until `bram_dout_read`
- `bram_dout_read` in 1 — consumer accepted `bram_dout`
- `port1_din` in 32 — command: `[3:0]` opcode, `[15:8]` channel mask (bits ≥ NCH ignored)
- `port1_valid` in 1 — command present
- `port1_read` out 1 — one-cycle command-consumed pulse
- `port2_dout` out 32 — status: `[3:0]` opcode echo, `[7]` error, `[15:8]` done-channel mask, others 0
- `port2_valid` out 1 — status valid, held until `port2_read`
- `port2_read` in 1 — ARM consumed status
- `leds` out 4 — current state code

## Operation
- Opcodes: 0 LOAD_A, 1 LOAD_B, 2 LOAD_M, 3 MULTIPLY, 4 WRITE, 5 CHAIN. All other opcodes are illegal.
- States (codes): IDLE 1, LOAD 2, START 3, WAIT 4, WRITE 5, STATUS 6.
- IDLE: on `port1_valid`, latch opcode and effective mask (`port1_din[8+:NCH]`), then decode:
  - LOAD_A/B/M -> LOAD
  - MULTIPLY -> START
  - WRITE -> WRITE
  - CHAIN: copy `result[i]` to `A[i]` for masked i in one cycle, then STATUS
  - illegal opcode or empty mask: error=1, no register changes, -> STATUS
- LOAD: on `bram_din_valid`, write slice i into the selected operand register of each masked channel; unmasked channels are unchanged; -> STATUS. No timeout is applied in LOAD.
- START: one-cycle `start` pulse to masked cores only. Clear the sticky done mask and timeout counter. -> WAIT.
- WAIT:
  - Each cycle, set sticky done bit i when core i `done` is high and i is masked; capture `result[i]` from the core on that cycle.
  - When sticky done == mask -> STATUS with error=0.
  - When the counter reaches `TIMEOUT` first -> STATUS with error=1; the done mask reports the channels that did finish.
- WRITE: drive captured results on masked slices, 0 elsewhere; assert `bram_dout_valid`. On `bram_dout_read` -> STATUS.
- STATUS: hold `port2_valid` and `port2_dout`. On `port2_read` -> IDLE.
- `port1_din` is ignored outside IDLE; commands are never queued.
- Result registers persist across commands until overwritten by a later MULTIPLY on that channel.

## Timing
- Reset values: `bram_dout`=0, `bram_dout_valid`=0, `port1_read`=0, `port2_valid`=0, `port2_dout`=0, `leds`=1. All operand, result and done registers are 0; state is IDLE; no core start is pulsed.
- `port1_read` is registered: it is high the cycle after IDLE sees `port1_valid`, for exactly 1 cycle.
- `port2_valid` rises the first cycle in STATUS and falls the cycle after `port2_read` is sampled.
- `bram_dout_valid` rises the first cycle in WRITE and falls the cycle after `bram_dout_read`.
- MULTIPLY latency: command accept -> START (1 cycle) -> WAIT (core latency + 1) -> STATUS.
- Per-cycle precedence: for `done` arriving on the same cycle as the timeout limit, done takes priority and the channel counts as finished.
- Reset mid-operation (any state) returns to IDLE next cycle and drops all valid outputs. Cores are reset with the wrapper.
- `bram_din_valid` outside LOAD and `bram_dout_read` outside WRITE are ignored.

## Test plan
- Reset, then LOAD_A/B/M with mask 0x03 (NCH=2): A=3, B=5, M=7 on ch0 and A=2, B=4, M=11 on ch1, then MULTIPLY -> status error=0, done=0x03. WRITE -> `bram_dout_valid` held until read; each slice equals the reference-model Montgomery product.
- MULTIPLY with mask 0x02 -> only core 1 sees `start`. WRITE -> slice 0 = 0, slice 1 = fresh result; ch0 operands are unchanged.
- Opcode 9, or opcode 3 with mask 0x00 -> `port2_dout[7]`=1, opcode echo correct, no `start` pulse, `port1_read` pulses once.
- Stub core that never asserts `done`, `TIMEOUT`=16 -> status reached exactly 16 cycles after WAIT entry, error=1, done=0x00.
- MULTIPLY, CHAIN mask 0x01, MULTIPLY -> ch0 computes mont(prev_result, B, M); ch1 is unaffected.
- `resetn` low for 1 cycle during WAIT and during STATUS with `port2_read` withheld -> all outputs return to reset values. A new LOAD_A command is accepted normally afterwards.

Source files
------------

// File: rtl/montgomery_multi_wrapper.sv
// Command-driven front end for NCH parallel Montgomery multiplier cores.
// Includes a bit-serial core computing a*b*2^-WIDTH mod m (m odd, a,b < m).
module montgomery #(
    parameter int WIDTH = 512
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] result,
    output logic             done
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] a_sh, b_r, m_r;
    logic [WIDTH+1:0] s, s_add, s_odd;
    logic [CW-1:0]    cnt;
    logic             busy, fin;

    always_comb begin
        s_add = s + (a_sh[0] ? {2'b00, b_r} : '0);
        s_odd = s_add[0] ? s_add + {2'b00, m_r} : s_add;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            a_sh   <= '0;
            b_r    <= '0;
            m_r    <= '0;
            s      <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            fin    <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            fin  <= 1'b0;
            if (start) begin
                a_sh <= a;
                b_r  <= b;
                m_r  <= m;
                s    <= '0;
                cnt  <= '0;
                busy <= 1'b1;
            end else if (busy) begin
                s    <= s_odd >> 1;
                a_sh <= a_sh >> 1;
                cnt  <= cnt + 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    busy <= 1'b0;
                    fin  <= 1'b1;
                end
            end else if (fin) begin
                // partial sum is below 2m, one subtraction fully reduces it
                result <= (s >= {2'b00, m_r}) ? WIDTH'(s - {2'b00, m_r})
                                              : s[WIDTH-1:0];
                done   <= 1'b1;
            end
        end
    end
endmodule

module montgomery_multi_wrapper #(
    parameter int WIDTH   = 512,
    parameter int NCH     = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NCH*WIDTH-1:0] bram_din,
    input  logic                 bram_din_valid,
    output logic [NCH*WIDTH-1:0] bram_dout,
    output logic                 bram_dout_valid,
    input  logic                 bram_dout_read,
    input  logic [31:0]          port1_din,
    input  logic                 port1_valid,
    output logic                 port1_read,
    output logic [31:0]          port2_dout,
    output logic                 port2_valid,
    input  logic                 port2_read,
    output logic [3:0]           leds
);
    typedef enum logic [2:0] {
        IDLE   = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        WAIT   = 3'd4,
        WRITE  = 3'd5,
        STATUS = 3'd6
    } state_t;

    localparam logic [3:0] OP_LOAD_A = 4'd0;
    localparam logic [3:0] OP_LOAD_B = 4'd1;
    localparam logic [3:0] OP_LOAD_M = 4'd2;
    localparam logic [3:0] OP_MULT   = 4'd3;
    localparam logic [3:0] OP_WRITE  = 4'd4;
    localparam logic [3:0] OP_CHAIN  = 4'd5;

    state_t           state, state_nx;
    logic [3:0]       op;
    logic [NCH-1:0]   mask, done_mask, done_nx, core_start, core_done;
    logic             err, p1_read, timeout_hit;
    logic [15:0]      tcnt;
    logic [WIDTH-1:0] a_r [NCH];
    logic [WIDTH-1:0] b_r [NCH];
    logic [WIDTH-1:0] m_r [NCH];
    logic [WIDTH-1:0] res_r [NCH];
    logic [WIDTH-1:0] core_res [NCH];

    logic [3:0]     cmd_op;
    logic [NCH-1:0] cmd_mask;
    logic           cmd_bad;
    logic           unused_cmd_bits;

    assign cmd_op          = port1_din[3:0];
    assign cmd_mask        = port1_din[8 +: NCH];
    assign cmd_bad         = (cmd_op > OP_CHAIN) || (cmd_mask == '0);
    assign unused_cmd_bits = ^{port1_din[31:16], port1_din[7:4]};
    assign done_nx         = done_mask | (core_done & mask);
    assign timeout_hit     = (tcnt == 16'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (port1_valid) begin
                    if (cmd_bad) begin
                        state_nx = STATUS;
                    end else begin
                        case (cmd_op)
                            OP_LOAD_A, OP_LOAD_B, OP_LOAD_M: state_nx = LOAD;
                            OP_MULT:  state_nx = START;
                            OP_WRITE: state_nx = WRITE;
                            default:  state_nx = STATUS;
                        endcase
                    end
                end
            end
            LOAD:   if (bram_din_valid) state_nx = STATUS;
            START:  state_nx = WAIT;
            WAIT:   if (done_nx == mask || timeout_hit) state_nx = STATUS;
            WRITE:  if (bram_dout_read) state_nx = STATUS;
            STATUS: if (port2_read) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            op        <= '0;
            mask      <= '0;
            err       <= 1'b0;
            done_mask <= '0;
            tcnt      <= '0;
            p1_read   <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                a_r[i]   <= '0;
                b_r[i]   <= '0;
                m_r[i]   <= '0;
                res_r[i] <= '0;
            end
        end else begin
            p1_read <= (state == IDLE) && port1_valid;
            case (state)
                IDLE: begin
                    if (port1_valid) begin
                        op   <= cmd_op;
                        mask <= cmd_mask;
                        err  <= cmd_bad;
                        if (!cmd_bad && cmd_op == OP_CHAIN) begin
                            for (int i = 0; i < NCH; i++)
                                if (cmd_mask[i]) a_r[i] <= res_r[i];
                        end
                    end
                end
                LOAD: begin
                    if (bram_din_valid) begin
                        for (int i = 0; i < NCH; i++) begin
                            if (mask[i]) begin
                                case (op)
                                    OP_LOAD_A: a_r[i] <= bram_din[i*WIDTH +: WIDTH];
                                    OP_LOAD_B: b_r[i] <= bram_din[i*WIDTH +: WIDTH];
                                    default:   m_r[i] <= bram_din[i*WIDTH +: WIDTH];
                                endcase
                            end
                        end
                    end
                end
                START: begin
                    done_mask <= '0;
                    tcnt      <= '0;
                end
                WAIT: begin
                    done_mask <= done_nx;
                    tcnt      <= tcnt + 16'd1;
                    for (int i = 0; i < NCH; i++)
                        if (core_done[i] && mask[i]) res_r[i] <= core_res[i];
                    // a done on the limit cycle still counts as success
                    if (done_nx != mask && timeout_hit) err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign core_start = (state == START) ? mask : '0;

    for (genvar g = 0; g < NCH; g++) begin : g_core
        montgomery #(.WIDTH(WIDTH)) u_core (
            .clk    (clk),
            .resetn (resetn),
            .start  (core_start[g]),
            .a      (a_r[g]),
            .b      (b_r[g]),
            .m      (m_r[g]),
            .result (core_res[g]),
            .done   (core_done[g])
        );
    end

    always_comb begin
        bram_dout = '0;
        for (int i = 0; i < NCH; i++)
            if (state == WRITE && mask[i])
                bram_dout[i*WIDTH +: WIDTH] = res_r[i];
    end

    assign bram_dout_valid = (state == WRITE);
    assign port2_valid     = (state == STATUS);
    assign port2_dout      = port2_valid
                           ? {16'h0, 8'(done_mask), err, 3'b000, op} : 32'h0;
    assign port1_read      = p1_read;
    assign leds            = {1'b0, state};
endmodule

// File: tb/tb_montgomery_multi_wrapper.sv
// Scoreboard bench for montgomery_multi_wrapper with a Montgomery reference model.
module tb_montgomery_multi_wrapper;
    localparam int W = 16;
    localparam int N = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           resetn = 1'b0;
    logic [N*W-1:0] bram_din = '0;
    logic           bram_din_valid = 1'b0;
    logic [N*W-1:0] bram_dout;
    logic           bram_dout_valid;
    logic           bram_dout_read = 1'b0;
    logic [31:0]    port1_din = '0;
    logic           port1_valid = 1'b0;
    logic           port1_read;
    logic [31:0]    port2_dout;
    logic           port2_valid;
    logic           port2_read = 1'b0;
    logic [3:0]     leds;

    logic [N*W-1:0] t_dout;
    logic           t_dout_valid;
    logic           t_p1_valid = 1'b0;
    logic           t_p1_read;
    logic [31:0]    t_p2_dout;
    logic           t_p2_valid;
    logic           t_p2_read = 1'b0;
    logic [3:0]     t_leds;

    montgomery_multi_wrapper #(.WIDTH(W), .NCH(N), .TIMEOUT(4096)) u_dut (
        .clk(clk), .resetn(resetn),
        .bram_din(bram_din), .bram_din_valid(bram_din_valid),
        .bram_dout(bram_dout), .bram_dout_valid(bram_dout_valid),
        .bram_dout_read(bram_dout_read),
        .port1_din(port1_din), .port1_valid(port1_valid),
        .port1_read(port1_read),
        .port2_dout(port2_dout), .port2_valid(port2_valid),
        .port2_read(port2_read), .leds(leds)
    );

    // the core needs W+2 cycles, so this instance always times out
    montgomery_multi_wrapper #(.WIDTH(W), .NCH(N), .TIMEOUT(8)) u_tmo (
        .clk(clk), .resetn(resetn),
        .bram_din(bram_din), .bram_din_valid(bram_din_valid),
        .bram_dout(t_dout), .bram_dout_valid(t_dout_valid),
        .bram_dout_read(1'b0),
        .port1_din(port1_din), .port1_valid(t_p1_valid),
        .port1_read(t_p1_read),
        .port2_dout(t_p2_dout), .port2_valid(t_p2_valid),
        .port2_read(t_p2_read), .leds(t_leds)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0]    st_q[$];
    logic [31:0]    st_m[$];
    logic [N*W-1:0] do_q[$];

    longint ma[N], mb[N], mm[N], mr[N];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // a*b*R^-1 mod m with R = 2^W, R^-1 found by search
    function automatic longint mont(input longint a, input longint b,
                                    input longint m);
        longint rinv = 0;
        longint x = 1;
        while (x < m && rinv == 0) begin
            if (((x << W) % m) == 1) rinv = x;
            x++;
        end
        return (((a * b) % m) * rinv) % m;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            ma[i] = 0; mb[i] = 0; mm[i] = 0; mr[i] = 0;
        end
    endfunction

    logic p2v_q = 1'b0;
    logic bdv_q = 1'b0;

    always @(negedge clk) begin
        if (resetn && port2_valid && !p2v_q) begin
            if (st_q.size() == 0) begin
                check("status_unexpected", port2_dout, 64'hdead);
            end else begin
                logic [31:0] e, mk;
                e  = st_q.pop_front();
                mk = st_m.pop_front();
                check("status_word", port2_dout & mk, e & mk);
            end
        end
        if (resetn && bram_dout_valid && !bdv_q) begin
            if (do_q.size() == 0) begin
                check("dout_unexpected", bram_dout, 64'hdead);
            end else begin
                logic [N*W-1:0] e;
                e = do_q.pop_front();
                check("bram_dout", bram_dout, e);
            end
        end
        p2v_q <= port2_valid;
        bdv_q <= bram_dout_valid;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] op, input logic [7:0] msk,
                        output logic [3:0] leds_after);
        port1_din   = {16'h0, msk, 4'h0, op};
        port1_valid = 1'b1;
        step();
        port1_valid = 1'b0;
        check("p1_read_pulse", port1_read, 1);
        leds_after = leds;
        step();
        check("p1_read_drop", port1_read, 0);
    endtask

    task automatic finish_status();
        int n = 0;
        while (!port2_valid && n < 200) begin
            step();
            n++;
        end
        check("status_seen", port2_valid, 1);
        step();
        check("status_held", port2_valid, 1);
        port2_read = 1'b1;
        step();
        port2_read = 1'b0;
        check("status_drop", port2_valid, 0);
        check("back_idle", leds, 1);
    endtask

    task automatic push_status(input logic [3:0] op, input logic e,
                               input logic [7:0] dm, input logic [31:0] mk);
        st_q.push_back({16'h0, dm, e, 3'b000, op});
        st_m.push_back(mk);
    endtask

    task automatic load_op(input logic [3:0] op, input logic [7:0] msk,
                           input longint v0, input longint v1);
        logic [3:0] la;
        longint v[N];
        v[0] = v0;
        v[1] = v1;
        push_status(op, 1'b0, 8'h0, 32'hff);
        send(op, msk, la);
        check("load_state", la, 2);
        for (int i = 0; i < N; i++) begin
            bram_din[i*W +: W] = W'(v[i]);
            if (msk[i]) begin
                if (op == 0) ma[i] = v[i];
                else if (op == 1) mb[i] = v[i];
                else mm[i] = v[i];
            end
        end
        bram_din_valid = 1'b1;
        step();
        bram_din_valid = 1'b0;
        finish_status();
    endtask

    task automatic load_all(input longint a0, input longint b0, input longint m0,
                            input longint a1, input longint b1, input longint m1);
        load_op(4'd0, 8'h03, a0, a1);
        load_op(4'd1, 8'h03, b0, b1);
        load_op(4'd2, 8'h03, m0, m1);
    endtask

    task automatic multiply(input logic [7:0] msk);
        logic [3:0] la;
        for (int i = 0; i < N; i++)
            if (msk[i]) mr[i] = mont(ma[i], mb[i], mm[i]);
        push_status(4'd3, 1'b0, msk & 8'h03, 32'hffff_ffff);
        send(4'd3, msk, la);
        check("start_state", la, 3);
        finish_status();
    endtask

    task automatic write_res(input logic [7:0] msk);
        logic [3:0]     la;
        logic [N*W-1:0] e;
        int n = 0;
        e = '0;
        for (int i = 0; i < N; i++)
            if (msk[i]) e[i*W +: W] = W'(mr[i]);
        do_q.push_back(e);
        push_status(4'd4, 1'b0, 8'h0, 32'hff);
        send(4'd4, msk, la);
        while (!bram_dout_valid && n < 50) begin
            step();
            n++;
        end
        check("dout_seen", bram_dout_valid, 1);
        repeat (3) step();
        check("dout_held", bram_dout_valid, 1);
        check("dout_held_data", bram_dout, e);
        bram_dout_read = 1'b1;
        step();
        bram_dout_read = 1'b0;
        check("dout_drop", bram_dout_valid, 0);
        finish_status();
    endtask

    task automatic chain(input logic [7:0] msk);
        logic [3:0] la;
        for (int i = 0; i < N; i++)
            if (msk[i]) ma[i] = mr[i];
        push_status(4'd5, 1'b0, 8'h0, 32'hff);
        send(4'd5, msk, la);
        finish_status();
    endtask

    task automatic bad_cmd(input logic [3:0] op, input logic [7:0] msk);
        logic [3:0] la;
        push_status(op, 1'b1, 8'h0, 32'hff);
        send(op, msk, la);
        check("bad_direct_status", la, 6);
        finish_status();
    endtask

    task automatic check_reset_outs();
        check("rst_leds", leds, 1);
        check("rst_p2_valid", port2_valid, 0);
        check("rst_p2_dout", port2_dout, 0);
        check("rst_p1_read", port1_read, 0);
        check("rst_dout_valid", bram_dout_valid, 0);
        check("rst_dout", bram_dout, 0);
    endtask

    task automatic pulse_reset();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        model_reset();
        check_reset_outs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] la;
        int n;
        model_reset();
        repeat (3) step();
        check_reset_outs();
        check("rst_tmo_leds", t_leds, 1);
        resetn = 1'b1;
        step();

        load_all(3, 5, 7, 2, 4, 11);
        multiply(8'h03);
        write_res(8'h03);

        multiply(8'h02);
        write_res(8'h03);
        write_res(8'h02);

        bad_cmd(4'd9, 8'h03);
        bad_cmd(4'd3, 8'h00);
        write_res(8'h03);

        multiply(8'h03);
        chain(8'h01);
        multiply(8'h01);
        write_res(8'h03);

        for (int k = 0; k < 4; k++) begin
            longint a[N], b[N], m[N];
            logic [7:0] msk;
            for (int i = 0; i < N; i++) begin
                m[i] = longint'($urandom_range(32767, 3) | 1);
                a[i] = longint'($urandom) % m[i];
                b[i] = longint'($urandom) % m[i];
            end
            load_all(a[0], b[0], m[0], a[1], b[1], m[1]);
            msk = 8'($urandom_range(3, 1));
            multiply(msk);
            write_res(8'h03);
            if (k % 2 == 1) begin
                chain(msk);
                multiply(8'h03);
                write_res(8'h03);
            end
        end

        port1_din  = 32'h0000_0303;
        t_p1_valid = 1'b1;
        step();
        t_p1_valid = 1'b0;
        n = 0;
        while (t_leds != 4 && n < 20) begin
            step();
            n++;
        end
        check("tmo_wait_entry", t_leds, 4);
        n = 0;
        while (t_leds != 6 && n < 40) begin
            step();
            n++;
        end
        check("tmo_cycles", n, 8);
        check("tmo_status", t_p2_dout, 32'h0000_0083);
        check("tmo_p2_valid", t_p2_valid, 1);
        t_p2_read = 1'b1;
        step();
        t_p2_read = 1'b0;
        check("tmo_idle", t_leds, 1);

        send(4'd3, 8'h03, la);
        n = 0;
        while (leds != 4 && n < 20) begin
            step();
            n++;
        end
        check("wait_before_reset", leds, 4);
        pulse_reset();

        push_status(4'd0, 1'b0, 8'h0, 32'hff);
        send(4'd0, 8'h03, la);
        bram_din       = {16'd9, 16'd6};
        bram_din_valid = 1'b1;
        step();
        bram_din_valid = 1'b0;
        repeat (3) step();
        check("status_withheld", port2_valid, 1);
        pulse_reset();

        load_op(4'd0, 8'h01, 4, 0);
        load_op(4'd1, 8'h03, 6, 1);
        load_op(4'd2, 8'h03, 13, 3);
        multiply(8'h03);
        write_res(8'h03);

        repeat (3) step();
        check("status_q_empty", st_q.size(), 0);
        check("dout_q_empty", do_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
